// File: rtl/mem_arbiter_if.sv
// Fetch, data and memory ports of the unified-memory arbiter.
// master = arbiter side; slave = requesters plus memory.
interface mem_arbiter_if #(
  parameter int BITS = 32
);
  logic              i_req;
  logic [BITS-1:0]   i_addr;
  logic              i_rdy;
  logic              i_valid;
  logic [BITS-1:0]   i_rdata;
  logic              i_err;

  logic              d_req;
  logic              d_we;
  logic [BITS/8-1:0] d_be;
  logic [BITS-1:0]   d_addr;
  logic [BITS-1:0]   d_wdata;
  logic              d_rdy;
  logic              d_valid;
  logic [BITS-1:0]   d_rdata;
  logic              d_err;

  logic              m_req;
  logic              m_we;
  logic [BITS/8-1:0] m_be;
  logic [BITS-1:0]   m_addr;
  logic [BITS-1:0]   m_wdata;
  logic              m_rdy;
  logic              m_valid;
  logic [BITS-1:0]   m_rdata;

  logic              owner;
  logic              busy;

  modport master (
    input  i_req, i_addr,
    output i_rdy, i_valid,
    output i_rdata, i_err,
    input  d_req, d_we, d_be,
    input  d_addr, d_wdata,
    output d_rdy, d_valid,
    output d_rdata, d_err,
    output m_req, m_we, m_be,
    output m_addr, m_wdata,
    input  m_rdy, m_valid, m_rdata,
    output owner, busy
  );

  modport slave (
    output i_req, i_addr,
    input  i_rdy, i_valid,
    input  i_rdata, i_err,
    output d_req, d_we, d_be,
    output d_addr, d_wdata,
    input  d_rdy, d_valid,
    input  d_rdata, d_err,
    input  m_req, m_we, m_be,
    input  m_addr, m_wdata,
    output m_rdy, m_valid, m_rdata,
    input  owner, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Serialises fetch and load/store onto one memory port.
// Data has priority; a streak counter bounds fetch starvation.
module mem_arbiter #(
  parameter int BITS       = 32,
  parameter int MAX_STREAK = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.master bus
);
  localparam int BW = BITS / 8;
  localparam int SW = $clog2(MAX_STREAK + 1);
  localparam int TW = $clog2(TIMEOUT);

  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_STREAK);
  localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT - 1);
  localparam logic [BITS-1:0] NOP      = BITS'(32'h13);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  typedef struct packed {
    logic            we;
    logic [BW-1:0]   be;
    logic [BITS-1:0] addr;
    logic [BITS-1:0] wdata;
  } mreq_t;

  logic [1:0]    state_q, state_d;
  logic [SW-1:0] streak_q, streak_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          owner_q, owner_d;
  mreq_t         mreq_q, mreq_d;

  logic in_idle;
  logic in_req;
  logic in_resp;
  logic any_req;
  logic pick_d;
  logic at_max;
  logic accept;
  logic done_to;
  logic done;

  assign in_idle = state_q == S_IDLE;
  assign in_req  = state_q == S_REQ;
  assign in_resp = state_q == S_RESP;
  assign any_req = bus.i_req | bus.d_req;
  assign at_max  = streak_q == STREAK_MAX;

  // data wins unless a waiting fetch has been passed over too often
  assign pick_d  = bus.d_req & (~bus.i_req | ~at_max);
  assign accept  = in_req & bus.m_rdy;
  assign done_to = in_resp & ~bus.m_valid
                 & (tcnt_q == TO_LAST);
  assign done    = (in_resp & bus.m_valid) | done_to;

  always_comb begin
    state_d  = state_q;
    streak_d = streak_q;
    tcnt_d   = tcnt_q;
    owner_d  = owner_q;
    mreq_d   = mreq_q;
    unique case (1'b1)
      in_idle: begin
        if (any_req) begin
          state_d = S_REQ;
          owner_d = pick_d;
          if (pick_d) begin
            mreq_d.we    = bus.d_we;
            mreq_d.be    = bus.d_be;
            mreq_d.addr  = bus.d_addr;
            mreq_d.wdata = bus.d_wdata;
            if (bus.i_req && !at_max)
              streak_d = streak_q + 1'b1;
          end else begin
            mreq_d.we    = 1'b0;
            mreq_d.be    = '1;
            mreq_d.addr  = bus.i_addr;
            mreq_d.wdata = '0;
            streak_d     = '0;
          end
        end
      end
      in_req: begin
        if (bus.m_rdy) begin
          state_d = S_RESP;
          tcnt_d  = '0;
        end
      end
      in_resp: begin
        if (done)
          state_d = S_IDLE;
        else
          tcnt_d = tcnt_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      streak_q <= '0;
      tcnt_q   <= '0;
      owner_q  <= 1'b0;
      mreq_q   <= '0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
      tcnt_q   <= tcnt_d;
      owner_q  <= owner_d;
      mreq_q   <= mreq_d;
    end
  end

  assign bus.m_req   = in_req;
  assign bus.m_we    = mreq_q.we;
  assign bus.m_be    = mreq_q.be;
  assign bus.m_addr  = mreq_q.addr;
  assign bus.m_wdata = mreq_q.wdata;
  assign bus.owner   = owner_q;
  assign bus.busy    = ~in_idle;

  assign bus.i_rdy   = accept & ~owner_q;
  assign bus.d_rdy   = accept & owner_q;
  assign bus.i_valid = done & ~owner_q;
  assign bus.d_valid = done & owner_q;
  assign bus.i_err   = done_to & ~owner_q;
  assign bus.d_err   = done_to & owner_q;

  // a timed-out fetch retires as a nop
  assign bus.i_rdata = done_to ? NOP : bus.m_rdata;
  assign bus.d_rdata = done_to ? '0 : bus.m_rdata;
endmodule
